gaplus_tile_layer: RTL



---
 rtl/gaplus_tile_layer.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/gaplus_tile_layer.sv
// gaplus_tile_layer: scrollable tilemap layer generator.
// Three-stage fetch (VRAM address -> char ROM address -> pixel select) with
// frame-synchronous shadowed scroll/control registers. Output latency is
// 3 VCLK from PH/PV to PIX/PRIO/OPQ.
// Optional build macro ROWSCROLL_EN adds a 32-entry per-row X scroll table.
module gaplus_tile_layer #(
    parameter int BPP      = 2,
    parameter int PAL_W    = 6,
    parameter int MAPW     = 6,
    parameter int MAPH     = 5,
    parameter int HOFS     = 16,
    parameter int HACT     = 288,
    parameter int VBL_LINE = 224
) (
    input  logic                   VCLK,
    input  logic                   RESET,
    input  logic [8:0]             PH,
    input  logic [8:0]             PV,
    input  logic                   REG_WE,
    input  logic [2:0]             REG_AD,
    input  logic [7:0]             REG_DT,
    output logic [MAPW+MAPH-1:0]   VRAM_A,
    input  logic [15:0]            VRAM_D,
    output logic [13:0]            CHR_A,
    input  logic [4*BPP-1:0]       CHR_D,
    output logic [PAL_W+BPP-1:0]   PIX,
    output logic                   PRIO,
    output logic                   OPQ
);

    localparam int SXW = MAPW + 3;
    localparam int SYW = MAPH + 3;
    localparam int AW  = MAPW + MAPH;

    // ---------------- register file: live and shadow copies ----------------
    logic [8:0] scx_live_q, scx_live_d;
    logic [7:0] scy_live_q, scy_live_d;
    logic       en_live_q, en_live_d;
    logic       flip_live_q, flip_live_d;

    logic [8:0] scx_sh_q, scx_sh_d;
    logic [7:0] scy_sh_q, scy_sh_d;
    logic       en_sh_q, en_sh_d;
    logic       flip_sh_q, flip_sh_d;

    logic       shadow_load;

`ifdef ROWSCROLL_EN
    logic [4:0] rs_idx_q, rs_idx_d;
    logic [7:0] rs_lo_q, rs_lo_d;
    logic [8:0] rs_tab_q [32];
    logic [8:0] rs_tab_d [32];
`endif

    assign shadow_load = (PV == 9'(VBL_LINE)) && (PH == 9'd0);

    // Register writes land in the live copy; shadow copy samples live once per frame
    always_comb begin
        scx_live_d  = scx_live_q;
        scy_live_d  = scy_live_q;
        en_live_d   = en_live_q;
        flip_live_d = flip_live_q;
`ifdef ROWSCROLL_EN
        rs_idx_d    = rs_idx_q;
        rs_lo_d     = rs_lo_q;
        rs_tab_d    = rs_tab_q;
`endif
        if (REG_WE) begin
            case (REG_AD)
                3'd0: scx_live_d[7:0] = REG_DT;
                3'd1: scx_live_d[8]   = REG_DT[0];
                3'd2: scy_live_d      = REG_DT;
                3'd3: begin
                    en_live_d   = REG_DT[0];
                    flip_live_d = REG_DT[1];
                end
`ifdef ROWSCROLL_EN
                3'd4: rs_idx_d = REG_DT[4:0];
                3'd5: rs_lo_d  = REG_DT;
                3'd6: rs_tab_d[rs_idx_q] = {REG_DT[0], rs_lo_q};
`endif
                default: ;
            endcase
        end

        // Shadow takes the pre-write live value, so a same-cycle write waits a frame
        scx_sh_d  = scx_sh_q;
        scy_sh_d  = scy_sh_q;
        en_sh_d   = en_sh_q;
        flip_sh_d = flip_sh_q;
        if (shadow_load) begin
            scx_sh_d  = scx_live_q;
            scy_sh_d  = scy_live_q;
            en_sh_d   = en_live_q;
            flip_sh_d = flip_live_q;
        end
    end

    // Register file state
    always_ff @(posedge VCLK or posedge RESET) begin
        if (RESET) begin
            scx_live_q  <= '0;
            scy_live_q  <= '0;
            en_live_q   <= 1'b0;
            flip_live_q <= 1'b0;
            scx_sh_q    <= '0;
            scy_sh_q    <= '0;
            en_sh_q     <= 1'b0;
            flip_sh_q   <= 1'b0;
`ifdef ROWSCROLL_EN
            rs_idx_q    <= '0;
            rs_lo_q     <= '0;
            rs_tab_q    <= '{default: '0};
`endif
        end else begin
            scx_live_q  <= scx_live_d;
            scy_live_q  <= scy_live_d;
            en_live_q   <= en_live_d;
            flip_live_q <= flip_live_d;
            scx_sh_q    <= scx_sh_d;
            scy_sh_q    <= scy_sh_d;
            en_sh_q     <= en_sh_d;
            flip_sh_q   <= flip_sh_d;
`ifdef ROWSCROLL_EN
            rs_idx_q    <= rs_idx_d;
            rs_lo_q     <= rs_lo_d;
            rs_tab_q    <= rs_tab_d;
`endif
        end
    end

    // ---------------- stage 0: screen -> map coordinates ----------------
    logic [8:0]     hx_raw;
    logic [8:0]     hx;
    logic [7:0]     vy;
    logic [8:0]     scx_eff;
    logic [SXW-1:0] sx;
    logic [SYW-1:0] sy;
    logic           win;

    logic [AW-1:0]  vram_a_q, vram_a_d;
    logic [2:0]     sx_lo_s1_q, sx_lo_s1_d;
    logic [2:0]     sy_lo_s1_q, sy_lo_s1_d;
    logic           flip_s1_q, flip_s1_d;
    logic           act_s1_q, act_s1_d;

`ifdef ROWSCROLL_EN
    logic [7:0]     sy_pre;
`endif

    // Flip mirrors both axes before scrolling; map coordinates wrap silently
    always_comb begin
        hx_raw = PH - 9'(HOFS);
        hx     = flip_sh_q ? (9'(HACT - 1) - hx_raw) : hx_raw;
        vy     = flip_sh_q ? (8'd255 - PV[7:0]) : PV[7:0];
`ifdef ROWSCROLL_EN
        // Row index comes from the Y position before any X adjustment
        sy_pre  = vy + scy_sh_q;
        scx_eff = scx_sh_q + rs_tab_q[sy_pre[7:3]];
`else
        scx_eff = scx_sh_q;
`endif
        sx  = SXW'(hx) + SXW'(scx_eff);
        sy  = SYW'(vy) + SYW'(scy_sh_q);
        win = ({1'b0, PH} >= 10'(HOFS)) && ({1'b0, PH} < 10'(HOFS + HACT));

        vram_a_d   = {sy[SYW-1:3], sx[SXW-1:3]};
        sx_lo_s1_d = sx[2:0];
        sy_lo_s1_d = sy[2:0];
        flip_s1_d  = flip_sh_q;
        act_s1_d   = win & en_sh_q;
    end

    // Stage 0 pipeline register
    always_ff @(posedge VCLK or posedge RESET) begin
        if (RESET) begin
            vram_a_q   <= '0;
            sx_lo_s1_q <= '0;
            sy_lo_s1_q <= '0;
            flip_s1_q  <= 1'b0;
            act_s1_q   <= 1'b0;
        end else begin
            vram_a_q   <= vram_a_d;
            sx_lo_s1_q <= sx_lo_s1_d;
            sy_lo_s1_q <= sy_lo_s1_d;
            flip_s1_q  <= flip_s1_d;
            act_s1_q   <= act_s1_d;
        end
    end

    assign VRAM_A = vram_a_q;

    // ---------------- stage 1: tile word -> char ROM address ----------------
    logic [8:0]       code;
    logic [13:0]      chr_a_q, chr_a_d;
    logic [PAL_W-1:0] pal_s2_q, pal_s2_d;
    logic             prio_s2_q, prio_s2_d;
    logic [1:0]       sel_s2_q, sel_s2_d;
    logic             flip_s2_q, flip_s2_d;
    logic             act_s2_q, act_s2_d;

    // Decode tile word and form {code, half, line} for the char ROM
    always_comb begin
        code      = {VRAM_D[15], VRAM_D[7:0]};
        chr_a_d   = 14'({code, sx_lo_s1_q[2], sy_lo_s1_q});
        pal_s2_d  = VRAM_D[8 +: PAL_W];
        prio_s2_d = VRAM_D[14];
        sel_s2_d  = sx_lo_s1_q[1:0];
        flip_s2_d = flip_s1_q;
        act_s2_d  = act_s1_q;
    end

    // Stage 1 pipeline register
    always_ff @(posedge VCLK or posedge RESET) begin
        if (RESET) begin
            chr_a_q   <= '0;
            pal_s2_q  <= '0;
            prio_s2_q <= 1'b0;
            sel_s2_q  <= '0;
            flip_s2_q <= 1'b0;
            act_s2_q  <= 1'b0;
        end else begin
            chr_a_q   <= chr_a_d;
            pal_s2_q  <= pal_s2_d;
            prio_s2_q <= prio_s2_d;
            sel_s2_q  <= sel_s2_d;
            flip_s2_q <= flip_s2_d;
            act_s2_q  <= act_s2_d;
        end
    end

    assign CHR_A = chr_a_q;

    // ---------------- stage 2: pixel select and output ----------------
    logic [1:0]             pix_idx;
    logic [BPP-1:0]         pen;
    logic [PAL_W+BPP-1:0]   pix_q, pix_d;
    logic                   prio_q, prio_d;
    logic                   opq_q, opq_d;

    // Gather the BPP planes of the selected pixel; flip reverses pixel order
    always_comb begin
        pix_idx = flip_s2_q ? (2'd3 - sel_s2_q) : sel_s2_q;
        pen     = '0;
        for (int unsigned b = 0; b < BPP; b++) begin
            pen[b] = CHR_D[4*b + pix_idx];
        end
        pix_d  = {pal_s2_q, pen};
        prio_d = prio_s2_q & act_s2_q;
        opq_d  = (pen != '0) & act_s2_q;
    end

    // Output register
    always_ff @(posedge VCLK or posedge RESET) begin
        if (RESET) begin
            pix_q  <= '0;
            prio_q <= 1'b0;
            opq_q  <= 1'b0;
        end else begin
            pix_q  <= pix_d;
            prio_q <= prio_d;
            opq_q  <= opq_d;
        end
    end

    assign PIX  = pix_q;
    assign PRIO = prio_q;
    assign OPQ  = opq_q;

endmodule
